// File: rtl/udma_rx_lin_arb.sv
// Round-robin arbiter merging N_CH uDMA RX linear channels into one registered
// beat slot feeding the L2 write port.
module udma_rx_lin_arb #(
  parameter int N_CH   = 7,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18,
  localparam int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          ch_valid_i,
  output logic [N_CH-1:0]          ch_ready_o,
  input  logic [N_CH*DATA_W-1:0]   ch_data_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [N_CH*2-1:0]        ch_size_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [ADDR_W-1:0]        out_addr_o,
  output logic [1:0]               out_size_o,
  output logic [ID_W-1:0]          out_ch_id_o
);

  localparam logic [ID_W:0]   N_CH_EXT = (ID_W+1)'(N_CH);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_CH - 1);

  logic                  out_valid_r;
  logic [DATA_W-1:0]     out_data_r;
  logic [ADDR_W-1:0]     out_addr_r;
  logic [1:0]            out_size_r;
  logic [ID_W-1:0]       out_ch_id_r;
  logic [ID_W-1:0]       rr_ptr_r;

  logic                  load_en_s;
  logic                  grant_found_s;
  logic [ID_W-1:0]       grant_idx_s;
  logic [ID_W-1:0]       grant_next_ptr_s;
  logic [ID_W:0]         sum_s;
  logic [ID_W:0]         cand_s;
  logic [N_CH-1:0]       ch_ready_s;

  assign load_en_s = ~out_valid_r | out_ready_i;

  // first requester at or after rr_ptr, wrapping modulo N_CH
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    sum_s         = '0;
    cand_s        = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_s  = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
      cand_s = (sum_s >= N_CH_EXT) ? (sum_s - N_CH_EXT) : sum_s;
      if (!grant_found_s && ch_valid_i[cand_s[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    grant_next_ptr_s = (grant_idx_s == LAST_ID) ? '0 : (grant_idx_s + ID_W'(1));
  end

  // one-hot accept toward the granted channel; silent during reset or stall
  always_comb begin
    ch_ready_s = '0;
    if (!rst_i && load_en_s && grant_found_s) begin
      ch_ready_s[grant_idx_s] = 1'b1;
    end else begin
      ch_ready_s = '0;
    end
  end

  // output slot and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_addr_r  <= '0;
      out_size_r  <= 2'b00;
      out_ch_id_r <= '0;
      rr_ptr_r    <= '0;
    end else if (load_en_s) begin
      if (grant_found_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= ch_data_i[int'(grant_idx_s)*DATA_W +: DATA_W];
        out_addr_r  <= ch_addr_i[int'(grant_idx_s)*ADDR_W +: ADDR_W];
        out_size_r  <= ch_size_i[int'(grant_idx_s)*2 +: 2];
        out_ch_id_r <= grant_idx_s;
        rr_ptr_r    <= grant_next_ptr_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign ch_ready_o  = ch_ready_s;
  // valid is forced low as soon as reset is seen, before the clearing edge
  assign out_valid_o = out_valid_r & ~rst_i;
  assign out_data_o  = out_data_r;
  assign out_addr_o  = out_addr_r;
  assign out_size_o  = out_size_r;
  assign out_ch_id_o = out_ch_id_r;

endmodule

// File: tb/tb_udma_rx_lin_arb.sv
// Bench for udma_rx_lin_arb: vector table for reset/round-robin/wrap/idle plus
// hand sequences for stall and mid-operation reset, backed by a beat scoreboard.
module tb_udma_rx_lin_arb;

  localparam int N_CH   = 7;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 18;
  localparam int ID_W   = 3;

  logic                   clk;
  logic                   rst;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH-1:0]        ch_ready;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*2-1:0]      ch_size;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [ADDR_W-1:0]      out_addr;
  logic [1:0]             out_size;
  logic [ID_W-1:0]        out_ch_id;

  udma_rx_lin_arb #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
    .ch_data_i(ch_data), .ch_addr_i(ch_addr), .ch_size_i(ch_size),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_addr_o(out_addr),
    .out_size_o(out_size), .out_ch_id_o(out_ch_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [6:0] valid;
    logic       rdy;
    logic [6:0] exp_chr;
    logic       exp_ov;
    logic       chk_id;
    logic [2:0] exp_id;
  } vec_t;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    logic [17:0] addr;
    logic [1:0]  size;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];

  int tests  = 0;
  int failed = 0;

  logic [31:0] d_arr [N_CH];
  logic [17:0] a_arr [N_CH];
  logic [1:0]  s_arr [N_CH];
  logic        fix_en = 1'b0;

  logic       m_valid = 1'b0;
  int         m_rr    = 0;

  logic [6:0] act_chr;
  logic       act_ov;
  logic [2:0] act_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [6:0] v, input logic rdy,
                              input logic [6:0] chr, input logic ov, input logic ci,
                              input logic [2:0] id);
    vec_t e;
    e.rst = r; e.valid = v; e.rdy = rdy; e.exp_chr = chr;
    e.exp_ov = ov; e.chk_id = ci; e.exp_id = id;
    vecs.push_back(e);
  endfunction

  // one clock: drive, compare against the model at the falling edge, advance the model
  task automatic step(input logic r, input logic [6:0] v, input logic rdy);
    logic       le;
    logic       gf;
    int         g;
    logic [6:0] exp_chr;
    beat_t      b;
    rst = r; ch_valid = v; out_ready = rdy;
    for (int k = 0; k < N_CH; k++) begin
      d_arr[k] = $urandom;
      a_arr[k] = 18'($urandom);
      s_arr[k] = 2'($urandom_range(0, 3));
    end
    if (fix_en) begin
      d_arr[3] = 32'hDEADBEEF; a_arr[3] = 18'h00100; s_arr[3] = 2'd2;
    end
    for (int k = 0; k < N_CH; k++) begin
      ch_data[k*DATA_W +: DATA_W] = d_arr[k];
      ch_addr[k*ADDR_W +: ADDR_W] = a_arr[k];
      ch_size[k*2 +: 2]           = s_arr[k];
    end
    le = !m_valid || rdy;
    gf = 1'b0; g = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (!gf && v[(m_rr + i) % N_CH]) begin gf = 1'b1; g = (m_rr + i) % N_CH; end
    end
    exp_chr = 7'h00;
    if (!r && le && gf) exp_chr[g] = 1'b1;
    @(negedge clk);
    act_chr = ch_ready; act_ov = out_valid; act_id = out_ch_id;
    check("sb_ch_ready", 64'(ch_ready), 64'(exp_chr));
    check("sb_out_valid", 64'(out_valid), 64'(m_valid && !r));
    if (m_valid && !r && sb.size() > 0) begin
      check("sb_id", 64'(out_ch_id), 64'(sb[0].id));
      check("sb_data", 64'(out_data), 64'(sb[0].data));
      check("sb_addr", 64'(out_addr), 64'(sb[0].addr));
      check("sb_size", 64'(out_size), 64'(sb[0].size));
    end
    if (r) begin
      m_valid = 1'b0; m_rr = 0; sb.delete();
    end else if (le) begin
      if (m_valid && sb.size() > 0) void'(sb.pop_front());
      if (gf) begin
        b.id = 3'(g); b.data = d_arr[g]; b.addr = a_arr[g]; b.size = s_arr[g];
        sb.push_back(b);
        m_valid = 1'b1;
        m_rr = (g == N_CH - 1) ? 0 : g + 1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ch_valid = '0; out_ready = 1'b1;
    ch_data = '0; ch_addr = '0; ch_size = '0;

    // reset with all channels requesting
    add(1'b1, 7'h7F, 1'b1, 7'h00, 1'b0, 1'b0, 3'd0);
    add(1'b1, 7'h7F, 1'b1, 7'h00, 1'b0, 1'b1, 3'd0);
    // back-to-back round-robin: 20 grants, ends with rr_ptr = 6
    for (int k = 0; k < 20; k++)
      add(1'b0, 7'h7F, 1'b1, 7'(7'h01 << (k % 7)), k > 0, k > 0, 3'((k + 6) % 7));
    // wrap/skip from rr_ptr 6 with channels 0 and 2
    add(1'b0, 7'h05, 1'b1, 7'h01, 1'b1, 1'b1, 3'd5);
    add(1'b0, 7'h05, 1'b1, 7'h04, 1'b1, 1'b1, 3'd0);
    add(1'b0, 7'h00, 1'b1, 7'h00, 1'b1, 1'b1, 3'd2);
    add(1'b0, 7'h00, 1'b1, 7'h00, 1'b0, 1'b0, 3'd0);
    // idle: single beat from channel 4, then rr_ptr 5 must be held
    add(1'b0, 7'h10, 1'b1, 7'h10, 1'b0, 1'b0, 3'd0);
    add(1'b0, 7'h00, 1'b1, 7'h00, 1'b1, 1'b1, 3'd4);
    add(1'b0, 7'h00, 1'b1, 7'h00, 1'b0, 1'b0, 3'd0);
    add(1'b0, 7'h00, 1'b1, 7'h00, 1'b0, 1'b0, 3'd0);
    add(1'b0, 7'h7F, 1'b1, 7'h20, 1'b0, 1'b0, 3'd0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].rdy);
      check($sformatf("vec%0d_ch_ready", i), 64'(act_chr), 64'(vecs[i].exp_chr));
      check($sformatf("vec%0d_out_valid", i), 64'(act_ov), 64'(vecs[i].exp_ov));
      if (vecs[i].chk_id)
        check($sformatf("vec%0d_out_id", i), 64'(act_id), 64'(vecs[i].exp_id));
    end

    // stall: hold channel 3 beat for 5 cycles while everyone requests
    step(1'b1, 7'h00, 1'b1);
    fix_en = 1'b1;
    step(1'b0, 7'h08, 1'b1);
    check("stall_grant3", 64'(act_chr), 64'h08);
    fix_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 7'h7F, 1'b0);
      check("stall_ch_ready", 64'(act_chr), 64'h00);
      check("stall_valid", 64'(out_valid), 64'h1);
      check("stall_data", 64'(out_data), 64'hDEADBEEF);
      check("stall_addr", 64'(out_addr), 64'h00100);
      check("stall_size", 64'(out_size), 64'h2);
      check("stall_id", 64'(out_ch_id), 64'h3);
    end
    step(1'b0, 7'h7F, 1'b1);
    check("stall_release_grant", 64'(act_chr), 64'h10);
    step(1'b0, 7'h00, 1'b1);
    check("stall_reload_valid", 64'(act_ov), 64'h1);
    check("stall_reload_id", 64'(act_id), 64'h4);

    // mid-operation reset discards the held channel 2 beat
    step(1'b1, 7'h00, 1'b1);
    step(1'b0, 7'h04, 1'b1);
    step(1'b0, 7'h00, 1'b0);
    check("midrst_held_valid", 64'(act_ov), 64'h1);
    check("midrst_held_id", 64'(act_id), 64'h2);
    step(1'b1, 7'h7F, 1'b0);
    check("midrst_during_ready", 64'(act_chr), 64'h00);
    step(1'b0, 7'h00, 1'b0);
    check("midrst_after_valid", 64'(act_ov), 64'h0);
    step(1'b0, 7'h00, 1'b1);
    check("midrst_no_replay", 64'(act_ov), 64'h0);
    step(1'b0, 7'h7F, 1'b1);
    check("midrst_rr_zero", 64'(act_chr), 64'h01);
    step(1'b0, 7'h00, 1'b1);
    check("midrst_first_id", 64'(act_id), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
